// File: rtl/score_game_ctrl.sv
// -----------------------------------------------------------------------------
// score_game_ctrl
//   Single-clock controller for a 4-digit seven-segment score display.
//   Generates the score tick internally, runs an IDLE/RUN/OVER game FSM, keeps
//   a saturating 4-digit BCD score and time-multiplexes the digits onto the
//   shared anode/segment pins with leading-zero blanking and a game-over blink.
//
// Ports
//   clk_100MHz      in   1   system clock, rising edge
//   reset_n         in   1   asynchronous active-low reset
//   status          in   1   level: 1 = run, 0 = pause
//   clear           in   1   sync pulse: zero the score
//   game_over       in   1   sync pulse: end the game, freeze the score
//   score_bcd       out  16  {thousands,hundreds,tens,ones} BCD
//   running         out  1   high while the FSM is in RUN
//   over            out  1   high while the FSM is in OVER
//   Anode_Activate  out  4   active-low digit enables, bit0 = ones digit
//   LED_out         out  7   active-low segments {a,b,c,d,e,f,g}
// -----------------------------------------------------------------------------
module score_game_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int SCAN_DIV  = 100_000,
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic        clk_100MHz,
    input  logic        reset_n,
    input  logic        status,
    input  logic        clear,
    input  logic        game_over,
    output logic [15:0] score_bcd,
    output logic        running,
    output logic        over,
    output logic [3:0]  Anode_Activate,
    output logic [6:0]  LED_out
);

    localparam int TICK_W  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [15:0] SCORE_MAX = 16'h9999;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    // BCD increment with per-digit carry ripple; the caller guards 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (result[i*4 +: 4] == 4'd9) begin
                    result[i*4 +: 4] = 4'd0;
                    carry            = 1'b1;
                end else begin
                    result[i*4 +: 4] = result[i*4 +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end else begin
                carry = 1'b0;
            end
        end
        return result;
    endfunction

    // Active-low {a..g} pattern for one BCD digit; non-BCD codes go dark.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    state_t               state_r, state_nxt_s;
    logic [15:0]          score_r, score_nxt_s;
    logic [TICK_W-1:0]    tick_cnt_r, tick_cnt_nxt_s, tick_cnt_adv_s;
    logic [BLINK_W-1:0]   blink_cnt_r, blink_cnt_nxt_s;
    logic                 blink_on_r, blink_on_nxt_s;
    logic                 tick_s;
    logic                 running_r, over_r;

    logic [SCAN_W-1:0]    scan_cnt_r;
    logic [1:0]           idx_r;
    logic [3:0]           anode_r, anode_nxt_s;
    logic [6:0]           led_r, led_nxt_s;
    logic [3:0]           digit_s;
    logic                 blank_s;

    assign tick_s         = (tick_cnt_r == TICK_LAST);
    assign tick_cnt_adv_s = tick_s ? '0 : (tick_cnt_r + TICK_W'(1));

    // Game FSM next state, score, tick and blink counter updates.
    always_comb begin
        state_nxt_s     = state_r;
        score_nxt_s     = score_r;
        tick_cnt_nxt_s  = tick_cnt_r;
        blink_cnt_nxt_s = blink_cnt_r;
        blink_on_nxt_s  = blink_on_r;
        case (state_r)
            ST_IDLE: begin
                if (game_over) begin
                    state_nxt_s     = ST_OVER;
                    blink_cnt_nxt_s = '0;
                    blink_on_nxt_s  = 1'b1;
                end else if (clear) begin
                    score_nxt_s    = 16'h0000;
                    tick_cnt_nxt_s = '0;
                end else if (status) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (game_over) begin
                    // A tick landing on the same edge still counts.
                    state_nxt_s     = ST_OVER;
                    tick_cnt_nxt_s  = tick_cnt_adv_s;
                    blink_cnt_nxt_s = '0;
                    blink_on_nxt_s  = 1'b1;
                    if (tick_s && (score_r != SCORE_MAX)) begin
                        score_nxt_s = bcd_inc(score_r);
                    end else begin
                        score_nxt_s = score_r;
                    end
                end else if (clear) begin
                    score_nxt_s    = 16'h0000;
                    tick_cnt_nxt_s = '0;
                end else if (!status) begin
                    // Pause: counter frozen so resume picks up mid-second.
                    state_nxt_s = ST_IDLE;
                end else begin
                    tick_cnt_nxt_s = tick_cnt_adv_s;
                    if (tick_s && (score_r == SCORE_MAX)) begin
                        state_nxt_s     = ST_OVER;
                        blink_cnt_nxt_s = '0;
                        blink_on_nxt_s  = 1'b1;
                    end else if (tick_s) begin
                        score_nxt_s = bcd_inc(score_r);
                    end else begin
                        score_nxt_s = score_r;
                    end
                end
            end
            ST_OVER: begin
                if (clear) begin
                    state_nxt_s     = ST_IDLE;
                    score_nxt_s     = 16'h0000;
                    blink_cnt_nxt_s = '0;
                end else if (blink_cnt_r == BLINK_LAST) begin
                    blink_cnt_nxt_s = '0;
                    blink_on_nxt_s  = ~blink_on_r;
                end else begin
                    blink_cnt_nxt_s = blink_cnt_r + BLINK_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Game state, score and counters; running/over registered alongside state.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            score_r     <= 16'h0000;
            tick_cnt_r  <= '0;
            blink_cnt_r <= '0;
            blink_on_r  <= 1'b1;
            running_r   <= 1'b0;
            over_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            score_r     <= score_nxt_s;
            tick_cnt_r  <= tick_cnt_nxt_s;
            blink_cnt_r <= blink_cnt_nxt_s;
            blink_on_r  <= blink_on_nxt_s;
            running_r   <= (state_nxt_s == ST_RUN);
            over_r      <= (state_nxt_s == ST_OVER);
        end
    end

    // Free-running digit scan: dwell counter and digit index.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt_r <= '0;
            idx_r      <= 2'd0;
        end else if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_r <= '0;
            idx_r      <= idx_r + 2'd1;
        end else begin
            scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
        end
    end

    assign digit_s = score_r[{idx_r, 2'b00} +: 4];

    // Leading-zero blank: digit and every higher digit are zero; ones never blanks.
    always_comb begin
        case (idx_r)
            2'd3:    blank_s = (score_r[15:12] == 4'd0);
            2'd2:    blank_s = (score_r[15:8]  == 8'd0);
            2'd1:    blank_s = (score_r[15:4]  == 12'd0);
            default: blank_s = 1'b0;
        endcase
    end

    // Anode/segment pattern for the currently selected digit.
    always_comb begin
        anode_nxt_s = 4'b1111;
        led_nxt_s   = 7'b1111111;
        if ((state_r == ST_OVER) && !blink_on_r) begin
            anode_nxt_s = 4'b1111;
            led_nxt_s   = 7'b1111111;
        end else if (blank_s) begin
            anode_nxt_s = ~(4'b0001 << idx_r);
            led_nxt_s   = 7'b1111111;
        end else begin
            anode_nxt_s = ~(4'b0001 << idx_r);
            led_nxt_s   = seg7(digit_s);
        end
    end

    // Display pins registered for glitch-free drive.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            anode_r <= 4'b1111;
            led_r   <= 7'b1111111;
        end else begin
            anode_r <= anode_nxt_s;
            led_r   <= led_nxt_s;
        end
    end

    assign score_bcd      = score_r;
    assign running        = running_r;
    assign over           = over_r;
    assign Anode_Activate = anode_r;
    assign LED_out        = led_r;

endmodule
